ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Downstream of the PS/2 receiver. Consumes the receiver's scancode byte and one-cycle valid strobe.
//  Decodes set-2 make/break sequences, including the E0 extended and F0 break prefixes.
//  Keeps a held/released state for six game keys and produces one-cycle movement/action pulses
//  for the player-update logic. Movement pulses include an internal auto-repeat.
// PARAMETERS
//  REPEAT_DELAY    25_000_000  cycles from a direction's make pulse to its first repeat pulse (0.5 s @ 50 MHz)
//  REPEAT_PERIOD    5_000_000  cycles between subsequent repeat pulses (0.1 s)
//  PREFIX_TIMEOUT     500_000  cycles a pending prefix waits for its next byte before it is discarded (10 ms)
// PORTS
//  CLOCK_50        in   1  system clock, all logic on posedge
//  Reset           in   1  synchronous, active-high reset
//  scancode        in   8  byte from the PS/2 receiver
//  scancode_valid  in   1  one-cycle strobe; scancode is sampled only when it is high
//  key_held        out  6  [0]up [1]down [2]left [3]right [4]action [5]esc; 1 = currently held
//  move_pulse      out  4  one-hot, one cycle: [0]up [1]down [2]left [3]right
//  action_pulse    out  1  one cycle, on make of action (space) only, never repeated
//  esc_pulse       out  1  one cycle, on make of esc only
//  unknown_pulse   out  1  one cycle when a complete sequence decodes to an unmapped key
// BEHAVIOUR
//  Clock and reset: one clock (CLOCK_50); reset is synchronous and active-high (Reset).
//  Reset: all outputs 0; decoder in IDLE; repeat counter, prefix timer and active_dir cleared.
//  Key map:
//   - up: 1D (W) or E0 75
//   - down: 1B (S) or E0 72
//   - left: 1C (A) or E0 6B
//   - right: 23 (D) or E0 74
//   - action: 29
//   - esc: 76
//   - Non-extended 75/72/6B/74 (keypad) are unmapped.
//  Decoder FSM. Transitions are taken only on cycles with scancode_valid=1:
//   - IDLE:   E0 -> EXT; F0 -> BRK; any other byte = make(code,ext=0), stay IDLE
//   - EXT:    F0 -> EXTBRK; E0 -> stay EXT; other byte = make(code,ext=1) -> IDLE
//   - BRK:    byte = break(code,ext=0) -> IDLE
//   - EXTBRK: byte = break(code,ext=1) -> IDLE
//   - E1 (pause) in IDLE: ignored, stay IDLE, no unknown_pulse
//   - Prefix timeout: in EXT/BRK/EXTBRK with no valid byte for PREFIX_TIMEOUT cycles -> IDLE.
//     The timer restarts on every accepted byte.
//  Timing:
//   - Byte accepted in cycle N: key_held and all pulses appear in cycle N+1 (latency 1).
//   - Make of a key already held (typematic) changes nothing and produces no pulse.
//   - Break of a key not held produces no pulse.
//  Active direction:
//   - A direction make whose key was not held emits move_pulse for it at N+1.
//     That direction becomes active_dir and the repeat counter loads REPEAT_DELAY.
//   - Break of active_dir: no pulse. active_dir becomes the highest-priority held direction
//     (up>down>left>right); the counter reloads REPEAT_DELAY. If none are held, the counter stops.
//   - Break of a non-active direction changes only key_held.
//   - A new make in the same cycle as counter expiry: the new make wins. Its pulse is emitted,
//     the expiry is dropped and the counter reloads.
//   - Counter width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). It counts down and never wraps.
//  Reset asserted mid-sequence or mid-hold: state clears next cycle and no pulse is emitted.
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined:
//   - On counter expiry while active_dir is held, emit move_pulse[active_dir] and reload REPEAT_PERIOD.
//  KEY_AUTOREPEAT_EN undefined:
//   - The repeat counter is not built; exactly one move_pulse is emitted per make.
//   - Releasing active_dir emits no pulse.
// STRUCTURE
//  Shared package ps2_pkg holds:
//   - scancode constants (SC_E0, SC_F0, SC_E1 and the key codes)
//   - key index constants (KEY_UP..KEY_ESC)
//   - decoder state encoding (IDLE, EXT, BRK, EXTBRK)
//  Sub-module ps2_repeat_timer: load/reload/stop down-counter with an expiry strobe.
//  It is instantiated only under KEY_AUTOREPEAT_EN.
// TESTING
//  Bench parameters: REPEAT_DELAY=10, REPEAT_PERIOD=4, PREFIX_TIMEOUT=8.
//  1. Byte 1D -> key_held=6'b000001 and move_pulse=4'b0001 one cycle later.
//     Then F0,1D -> key_held=0 with no pulse.
//  2. E0,74 -> key_held[3]=1 and move_pulse=4'b1000. E0,F0,74 -> key_held[3]=0 with no pulse.
//     Then 74 -> unknown_pulse=1 only.
//  3. (autorepeat) Hold 1D with make at N -> move_pulse[0] at N+1, N+11, N+15, N+19.
//     F0,1D stops the pulses.
//  4. Make 1C, then 1D, then F0,1D -> active_dir=left.
//     Next move_pulse[2] arrives 10 cycles after the break (with the macro); none without it.
//  5. E0, then idle 9 cycles, then 75 -> unknown_pulse=1 and key_held unchanged.
//     29 -> action_pulse once, even with repeated 29 bytes.
//  6. Hold 1D and 29, then assert Reset for 1 cycle mid-hold -> all outputs 0 next cycle
//     and no pulses afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: set-2 scancodes, game-key indices and decoder states shared by the PS/2 key tracker
package ps2_pkg;
    localparam logic [7:0] SC_E0 = 8'hE0, SC_F0 = 8'hF0, SC_E1 = 8'hE1;
    localparam logic [7:0] SC_W = 8'h1D, SC_S = 8'h1B, SC_A = 8'h1C, SC_D = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29, SC_ESC = 8'h76;
    localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
    localparam logic [2:0] KEY_UP = 3'd0, KEY_DOWN = 3'd1, KEY_LEFT = 3'd2, KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_ACTION = 3'd4, KEY_ESC = 3'd5, KEY_NONE = 3'd7;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} dec_state_t;
    // Arrow keys only count when E0-prefixed; the bare codes are keypad keys
    function automatic logic [2:0] key_index(input logic [7:0] code, input logic ext);
        return ext ? (code == SC_UP ? KEY_UP : code == SC_DOWN ? KEY_DOWN :
                      code == SC_LEFT ? KEY_LEFT : code == SC_RIGHT ? KEY_RIGHT : KEY_NONE)
                   : (code == SC_W ? KEY_UP : code == SC_S ? KEY_DOWN : code == SC_A ? KEY_LEFT :
                      code == SC_D ? KEY_RIGHT : code == SC_SPACE ? KEY_ACTION :
                      code == SC_ESC ? KEY_ESC : KEY_NONE);
    endfunction
endpackage

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: scancode stream from the receiver, key state and event pulses to the game
interface ps2_key_tracker_if;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic [5:0] key_held;
    logic [3:0] move_pulse;
    logic       action_pulse;
    logic       esc_pulse;
    logic       unknown_pulse;
    modport master (output scancode, scancode_valid,
                    input key_held, move_pulse, action_pulse, esc_pulse, unknown_pulse);
    modport slave (input scancode, scancode_valid,
                   output key_held, move_pulse, action_pulse, esc_pulse, unknown_pulse);
endinterface

// File: rtl/ps2_repeat_timer.sv
// ps2_repeat_timer: loadable down-counter; expire strobes on the last counted cycle, then it idles at 0
module ps2_repeat_timer #(
    parameter int W = 8
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         stop,
    output logic         expire
);
    logic [W-1:0] cnt;
    assign expire = cnt == W'(1);
    always_ff @(posedge CLOCK_50)
        if (Reset || stop) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: set-2 make/break decoder driving held-key state and one-cycle game pulses.
// Define KEY_AUTOREPEAT_EN to build the movement auto-repeat timer.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000,
    parameter int PREFIX_TIMEOUT = 500_000
) (
    input logic CLOCK_50,
    input logic Reset,
    ps2_key_tracker_if.slave bus
);
    localparam int PW = $clog2(PREFIX_TIMEOUT + 1);
    dec_state_t    state, state_n;
    logic [PW-1:0] ptimer;
    logic          make, brk, ext, is_dir, mk_new, bk;
    logic [2:0]    k;
    logic [7:0]    held8;
    logic [5:0]    held_n;
    logic [3:0]    dir_onehot, move_n;
    always_comb begin
        state_n = state;
        make = 1'b0;
        brk = 1'b0;
        ext = 1'b0;
        if (bus.scancode_valid)
            case (state)
                IDLE: begin
                    state_n = bus.scancode == SC_E0 ? EXT : bus.scancode == SC_F0 ? BRK : IDLE;
                    make = !(bus.scancode inside {SC_E0, SC_F0, SC_E1});
                end
                EXT: begin
                    state_n = bus.scancode == SC_F0 ? EXTBRK : bus.scancode == SC_E0 ? EXT : IDLE;
                    make = !(bus.scancode inside {SC_E0, SC_F0});
                    ext = 1'b1;
                end
                BRK: begin
                    state_n = IDLE;
                    brk = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    brk = 1'b1;
                    ext = 1'b1;
                end
            endcase
        else if (state != IDLE && ptimer == PW'(PREFIX_TIMEOUT - 1))
            state_n = IDLE;
    end
    assign k          = key_index(bus.scancode, ext);
    assign held8      = {2'b00, bus.key_held};
    assign is_dir     = k < KEY_ACTION;
    assign mk_new     = make && k != KEY_NONE && !held8[k];
    assign bk         = brk && k != KEY_NONE && held8[k];
    assign held_n     = (bus.key_held & ~(bk ? 6'(1) << k : 6'b0)) | (mk_new ? 6'(1) << k : 6'b0);
    assign dir_onehot = 4'(1) << k[1:0];
`ifdef KEY_AUTOREPEAT_EN
    localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [1:0] active_dir, pri_dir;
    logic       dir_make, act_brk, expire, rep;
    assign dir_make = mk_new && is_dir;
    assign act_brk  = bk && is_dir && k[1:0] == active_dir;
    assign pri_dir  = held_n[0] ? 2'd0 : held_n[1] ? 2'd1 : held_n[2] ? 2'd2 : 2'd3;
    // A fresh make or a release of the active key pre-empts an expiry in the same cycle
    assign rep      = expire && !dir_make && !act_brk && bus.key_held[active_dir];
    ps2_repeat_timer #(.W(CW)) u_timer (
        .CLOCK_50,
        .Reset,
        .load    (dir_make || (act_brk && |held_n[3:0]) || rep),
        .load_val((dir_make || act_brk) ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD)),
        .stop    (act_brk && ~|held_n[3:0]),
        .expire
    );
    always_ff @(posedge CLOCK_50)
        if (Reset) active_dir <= 2'd0;
        else if (dir_make) active_dir <= k[1:0];
        else if (act_brk) active_dir <= pri_dir;
    assign move_n = dir_make ? dir_onehot : rep ? 4'(1) << active_dir : 4'b0;
`else
    assign move_n = (mk_new && is_dir) ? dir_onehot : 4'b0;
`endif
    always_ff @(posedge CLOCK_50)
        if (Reset) begin
            state             <= IDLE;
            ptimer            <= '0;
            bus.key_held      <= '0;
            bus.move_pulse    <= '0;
            bus.action_pulse  <= 1'b0;
            bus.esc_pulse     <= 1'b0;
            bus.unknown_pulse <= 1'b0;
        end else begin
            state             <= state_n;
            ptimer            <= (bus.scancode_valid || state_n == IDLE) ? '0 : ptimer + PW'(1);
            bus.key_held      <= held_n;
            bus.move_pulse    <= move_n;
            bus.action_pulse  <= mk_new && k == KEY_ACTION;
            bus.esc_pulse     <= mk_new && k == KEY_ESC;
            bus.unknown_pulse <= (make || brk) && k == KEY_NONE;
        end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed scancode sequences; expected outputs are queued per cycle and
// compared every cycle (unlisted cycles expect no pulses and an unchanged key_held).
module tb_ps2_key_tracker;
    logic CLOCK_50 = 1'b0;
    logic Reset = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_key_tracker_if bus ();
    ps2_key_tracker #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4), .PREFIX_TIMEOUT(8)) dut (
        .CLOCK_50(CLOCK_50),
        .Reset(Reset),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        logic [12:0] val;
    } exp_t;
    exp_t        q[$];
    int          cyc = 0, last = 0, checks = 0, errors = 0;
    logic        chk_en = 1'b0;
    logic [5:0]  held_exp = 6'b0;
    string       tag = "reset";

    always @(negedge CLOCK_50) begin
        logic [12:0] want, got;
        cyc = cyc + 1;
        want = {held_exp, 7'b0};
        if (q.size() != 0 && q[0].cyc == cyc) begin
            want = q[0].val;
            held_exp = want[12:7];
            void'(q.pop_front());
        end
        got = {bus.key_held, bus.move_pulse, bus.action_pulse, bus.esc_pulse, bus.unknown_pulse};
        if (chk_en) begin
            checks++;
            assert (got === want) else begin
                errors++;
                $error("FAIL %s cyc %0d held/move/act/esc/unk got %b_%b_%b%b%b want %b_%b_%b%b%b",
                       tag, cyc, got[12:7], got[6:3], got[2], got[1], got[0],
                       want[12:7], want[6:3], want[2], want[1], want[0]);
            end
        end
    end

    task automatic tick(logic v, logic [7:0] b);
        @(negedge CLOCK_50);
        #1;
        Reset = 1'b0;
        bus.scancode = b;
        bus.scancode_valid = v;
        last = cyc;
    endtask

    task automatic send(logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle(int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic exp_out(int d, logic [5:0] h, logic [3:0] m, logic a, logic e, logic u);
        exp_t x;
        int   i;
        x.cyc = last + d;
        x.val = {h, m, a, e, u};
        i = q.size();
        while (i > 0 && q[i-1].cyc > x.cyc) i--;
        q.insert(i, x);
    endtask

    initial begin
        bus.scancode = 8'h00;
        bus.scancode_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk_en = 1'b1;
        idle(2);
        tag = "t1_make_w";
        send(8'h1D); exp_out(1, 6'b000001, 4'b0001, 0, 0, 0);
        tag = "t1_break_w";
        send(8'hF0);
        send(8'h1D); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        idle(3);
        tag = "t2_ext_right";
        send(8'hE0);
        send(8'h74); exp_out(1, 6'b001000, 4'b1000, 0, 0, 0);
        tag = "t2_ext_break";
        send(8'hE0);
        send(8'hF0);
        send(8'h74); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        tag = "t2_keypad_unknown";
        send(8'h74); exp_out(1, 6'b000000, 4'b0000, 0, 0, 1);
        idle(3);
        tag = "t3_hold_repeat";
        send(8'h1D); exp_out(1, 6'b000001, 4'b0001, 0, 0, 0);
`ifdef KEY_AUTOREPEAT_EN
        exp_out(11, 6'b000001, 4'b0001, 0, 0, 0);
        exp_out(15, 6'b000001, 4'b0001, 0, 0, 0);
        exp_out(19, 6'b000001, 4'b0001, 0, 0, 0);
`endif
        idle(18);
        tag = "t3_release";
        send(8'hF0);
        send(8'h1D); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        idle(15);
        tag = "t4_left_then_up";
        send(8'h1C); exp_out(1, 6'b000100, 4'b0100, 0, 0, 0);
        send(8'h1D); exp_out(1, 6'b000101, 4'b0001, 0, 0, 0);
        tag = "t4_break_active";
        send(8'hF0);
        send(8'h1D); exp_out(1, 6'b000100, 4'b0000, 0, 0, 0);
`ifdef KEY_AUTOREPEAT_EN
        exp_out(11, 6'b000100, 4'b0100, 0, 0, 0);
`endif
        idle(10);
        tag = "t4_release_left";
        send(8'hF0);
        send(8'h1C); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        idle(15);
        tag = "t5_prefix_timeout";
        send(8'hE0);
        idle(9);
        send(8'h75); exp_out(1, 6'b000000, 4'b0000, 0, 0, 1);
        tag = "t5_prefix_in_time";
        send(8'hE0);
        idle(7);
        send(8'h74); exp_out(1, 6'b001000, 4'b1000, 0, 0, 0);
        send(8'hE0);
        send(8'hF0);
        send(8'h74); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        tag = "t5_action_once";
        send(8'h29); exp_out(1, 6'b010000, 4'b0000, 1, 0, 0);
        send(8'h29);
        send(8'h29);
        send(8'hF0);
        send(8'h29); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        tag = "t5_esc_and_pause";
        send(8'h76); exp_out(1, 6'b100000, 4'b0000, 0, 1, 0);
        send(8'hE1);
        send(8'hF0);
        send(8'h76); exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        tag = "t5_break_not_held";
        send(8'hF0);
        send(8'h1B);
        idle(3);
        tag = "t6_hold_then_reset";
        send(8'h1D); exp_out(1, 6'b000001, 4'b0001, 0, 0, 0);
        send(8'h29); exp_out(1, 6'b010001, 4'b0000, 1, 0, 0);
        @(negedge CLOCK_50);
        #1;
        Reset = 1'b1;
        bus.scancode_valid = 1'b0;
        last = cyc;
        exp_out(1, 6'b000000, 4'b0000, 0, 0, 0);
        tag = "t6_after_reset";
        idle(20);
        tag = "end_queue";
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL %s pending %0d want 0", tag, q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
